// File: rtl/feature_pkg.sv
// rtl/feature_pkg.sv - shared MFCC feature types and constants
package feature_pkg;

  localparam int NUM_FEATURES = 16;
  localparam int DATA_WIDTH   = 16;

  typedef logic signed [DATA_WIDTH-1:0] feature_t;
  typedef feature_t [NUM_FEATURES-1:0]  feature_vec_t;

  typedef enum logic {
    WR_FILL = 1'b0,
    WR_DROP = 1'b1
  } wr_state_t;

endpackage

// File: rtl/feature_vector_collector_if.sv
// rtl/feature_vector_collector_if.sv - serial feature stream in, parallel vector out
interface feature_vector_collector_if #(
  parameter int NUM_FEATURES = feature_pkg::NUM_FEATURES,
  parameter int DATA_WIDTH   = feature_pkg::DATA_WIDTH,
  parameter int ERR_WIDTH    = 16
);

  logic signed [DATA_WIDTH-1:0]           feature_data_in;
  logic                                   feature_valid_in;
  logic                                   feature_last_in;
  logic                                   feature_ready_out;
  logic [NUM_FEATURES-1:0][DATA_WIDTH-1:0] vector_data_out;
  logic                                   vector_valid_out;
  logic                                   vector_ready_in;
  logic                                   frame_error_out;
  logic [ERR_WIDTH-1:0]                   error_count_out;

  modport slave (
    input  feature_data_in, feature_valid_in, feature_last_in, vector_ready_in,
    output feature_ready_out, vector_data_out, vector_valid_out,
    output frame_error_out, error_count_out
  );

  modport master (
    output feature_data_in, feature_valid_in, feature_last_in, vector_ready_in,
    input  feature_ready_out, vector_data_out, vector_valid_out,
    input  frame_error_out, error_count_out
  );

endinterface

// File: rtl/feature_pingpong.sv
// rtl/feature_pingpong.sv - two-bank vector buffer with read-side valid/ready
module feature_pingpong #(
  parameter int NUM_FEATURES = feature_pkg::NUM_FEATURES,
  parameter int DATA_WIDTH   = feature_pkg::DATA_WIDTH,
  parameter int IDX_W        = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_en,
  input  logic [IDX_W-1:0]                       wr_idx,
  input  logic signed [DATA_WIDTH-1:0]           wr_data,
  input  logic                                   commit,
  output logic                                   wr_ready,
  output logic [NUM_FEATURES-1:0][DATA_WIDTH-1:0] rd_data,
  output logic                                   rd_valid,
  input  logic                                   rd_ready
);

  logic [1:0][NUM_FEATURES-1:0][DATA_WIDTH-1:0] bank;
  logic       wr_bank;
  logic       rd_bank;
  logic [1:0] full_cnt;
  logic       live;
  logic       consume;

  assign consume = rd_valid && rd_ready;

  // live holds ready low during reset and raises it on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      full_cnt <= 2'd0;
      live     <= 1'b0;
    end else begin
      live <= 1'b1;
      if (wr_en) begin
        bank[wr_bank][wr_idx] <= wr_data;
      end
      if (commit) begin
        wr_bank <= ~wr_bank;
      end
      if (consume) begin
        rd_bank <= ~rd_bank;
      end
      if (commit && !consume) begin
        full_cnt <= full_cnt + 2'd1;
      end else if (!commit && consume) begin
        full_cnt <= full_cnt - 2'd1;
      end
    end
  end

  assign wr_ready = live && (full_cnt != 2'd2);
  assign rd_valid = (full_cnt != 2'd0);
  assign rd_data  = bank[rd_bank];

endmodule

// File: rtl/feature_vector_collector.sv
// rtl/feature_vector_collector.sv - frame checker and vector assembler for the MFCC stream
module feature_vector_collector #(
  parameter int NUM_FEATURES = feature_pkg::NUM_FEATURES,
  parameter int DATA_WIDTH   = feature_pkg::DATA_WIDTH,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  feature_vector_collector_if.slave   fv
);

  localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  feature_pkg::wr_state_t state;
  feature_pkg::wr_state_t state_nx;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_nx;
  logic                   ready;
  logic                   beat_ok;
  logic                   wr_en;
  logic                   commit;
  logic                   frame_bad;
  logic [ERR_WIDTH-1:0]   err_cnt;
  logic                   err_pulse;

  assign beat_ok = fv.feature_valid_in && ready;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= feature_pkg::WR_FILL;
      idx       <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      err_pulse <= frame_bad;
      if (frame_bad && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_WIDTH'(1);
      end
    end
  end

  // partial data of a short frame stays in the write bank and is simply overwritten
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    wr_en     = 1'b0;
    commit    = 1'b0;
    frame_bad = 1'b0;
    case (state)
      feature_pkg::WR_FILL: begin
        if (beat_ok) begin
          wr_en = 1'b1;
          if (idx == LAST_IDX) begin
            idx_nx = '0;
            if (fv.feature_last_in) begin
              commit = 1'b1;
            end else begin
              state_nx = feature_pkg::WR_DROP;
            end
          end else if (fv.feature_last_in) begin
            idx_nx    = '0;
            frame_bad = 1'b1;
          end else begin
            idx_nx = idx + IDX_W'(1);
          end
        end
      end
      feature_pkg::WR_DROP: begin
        if (beat_ok && fv.feature_last_in) begin
          frame_bad = 1'b1;
          state_nx  = feature_pkg::WR_FILL;
        end
      end
      default: state_nx = feature_pkg::WR_FILL;
    endcase
  end

  feature_pingpong #(
    .NUM_FEATURES (NUM_FEATURES),
    .DATA_WIDTH   (DATA_WIDTH),
    .IDX_W        (IDX_W)
  ) u_pingpong (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .wr_en    (wr_en),
    .wr_idx   (idx),
    .wr_data  (fv.feature_data_in),
    .commit   (commit),
    .wr_ready (ready),
    .rd_data  (fv.vector_data_out),
    .rd_valid (fv.vector_valid_out),
    .rd_ready (fv.vector_ready_in)
  );

  assign fv.feature_ready_out = ready;
  assign fv.frame_error_out   = err_pulse;
  assign fv.error_count_out   = err_cnt;

endmodule

// File: tb/tb_feature_vector_collector.sv
// tb/tb_feature_vector_collector.sv - bench for feature_vector_collector
module tb_feature_vector_collector;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int EW = 4;
  localparam int VW = N * DW;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  feature_vector_collector_if #(.NUM_FEATURES(N), .DATA_WIDTH(DW), .ERR_WIDTH(EW)) fv();

  feature_vector_collector #(.NUM_FEATURES(N), .DATA_WIDTH(DW), .ERR_WIDTH(EW)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .fv       (fv)
  );

  int total = 0;
  int bad   = 0;

  // reference model: completed vectors waiting for the consumer, beats of the frame in progress
  logic [VW-1:0] mq[$];
  logic [DW-1:0] cur[$];
  bit            m_drop;
  bit            m_live;
  bit            m_pulse;
  int            m_err;

  bit            last_acc;
  logic [VW-1:0] last_vec;
  int            n_consumed = 0;
  int            n_pulses   = 0;

  typedef struct {
    int nbeats;
    int base;
    int exp_pulses;
    int exp_err;
    int exp_vecs;
  } frame_rec_t;

  frame_rec_t tbl[8];

  function automatic logic [VW-1:0] build(int base);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(base + k);
    return v;
  endfunction

  function automatic logic [VW-1:0] pack_cur();
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = cur[k];
    return v;
  endfunction

  task automatic chk(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    cur.delete();
    m_drop  = 1'b0;
    m_live  = 1'b0;
    m_pulse = 1'b0;
    m_err   = 0;
  endtask

  task automatic check_outputs();
    int exp_cnt;
    exp_cnt = (m_err > ERR_MAX) ? ERR_MAX : m_err;
    chk("ready", VW'(fv.feature_ready_out), VW'(rst_n && m_live && (mq.size() < 2)));
    chk("valid", VW'(fv.vector_valid_out), VW'(rst_n && (mq.size() > 0)));
    chk("err_pulse", VW'(fv.frame_error_out), VW'(m_pulse));
    chk("err_count", VW'(fv.error_count_out), VW'(exp_cnt));
    if (mq.size() > 0) chk("vec_data", fv.vector_data_out, mq[0]);
    else if (!rst_n) chk("rst_data", fv.vector_data_out, '0);
  endtask

  task automatic cycle();
    bit            acc_m;
    bit            cons_m;
    logic [DW-1:0] d;
    bit            l;
    acc_m  = rst_n && fv.feature_valid_in && m_live && (mq.size() < 2);
    cons_m = rst_n && fv.vector_ready_in && (mq.size() > 0);
    last_acc = fv.feature_valid_in && fv.feature_ready_out;
    if (fv.vector_valid_out && fv.vector_ready_in) begin
      last_vec = fv.vector_data_out;
      n_consumed++;
    end
    d = fv.feature_data_in;
    l = fv.feature_last_in;
    @(posedge clk);
    m_pulse = 1'b0;
    if (!rst_n) begin
      model_clear();
    end else begin
      if (cons_m) void'(mq.pop_front());
      if (acc_m) begin
        if (m_drop) begin
          if (l) begin
            m_drop  = 1'b0;
            m_err++;
            m_pulse = 1'b1;
          end
        end else begin
          cur.push_back(d);
          if (l) begin
            if (cur.size() == N) mq.push_back(pack_cur());
            else begin
              m_err++;
              m_pulse = 1'b1;
            end
            cur.delete();
          end else if (cur.size() == N) begin
            m_drop = 1'b1;
            cur.delete();
          end
        end
      end
      m_live = 1'b1;
    end
    #1;
    check_outputs();
    if (fv.frame_error_out) n_pulses++;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs();
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic send_frame(int nbeats, int last_at, int base, bit ready_on_last);
    int n;
    for (int i = 0; i < nbeats; i++) begin
      fv.feature_valid_in = 1'b1;
      fv.feature_data_in  = DW'(base + i);
      fv.feature_last_in  = (i == last_at);
      if (ready_on_last && (i == nbeats - 1)) fv.vector_ready_in = 1'b1;
      n = 0;
      do begin
        cycle();
        n++;
      end while (!last_acc && n < 100);
      chk("beat_accept", VW'(last_acc), VW'(1));
    end
    fv.feature_valid_in = 1'b0;
    fv.feature_last_in  = 1'b0;
  endtask

  initial begin
    int p0, v0, p16, b, len;

    tbl[0] = '{16,    0, 0, 0, 1};
    tbl[1] = '{10,   50, 1, 1, 0};
    tbl[2] = '{16, 1000, 0, 1, 1};
    tbl[3] = '{20,    7, 1, 2, 0};
    tbl[4] = '{16, -500, 0, 2, 1};
    tbl[5] = '{ 1,    3, 1, 3, 0};
    tbl[6] = '{17,   90, 1, 4, 0};
    tbl[7] = '{16, 32752, 0, 4, 1};

    fv.feature_valid_in = 1'b0;
    fv.feature_last_in  = 1'b0;
    fv.feature_data_in  = '0;
    fv.vector_ready_in  = 1'b0;
    model_clear();
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    for (int e = 0; e < 8; e++) begin
      p0 = n_pulses;
      v0 = n_consumed;
      fv.vector_ready_in = 1'b1;
      send_frame(tbl[e].nbeats, tbl[e].nbeats - 1, tbl[e].base, 1'b0);
      repeat (2) cycle();
      chk("tbl_pulses", VW'(n_pulses - p0), VW'(tbl[e].exp_pulses));
      chk("tbl_err", VW'(fv.error_count_out), VW'(tbl[e].exp_err));
      chk("tbl_vecs", VW'(n_consumed - v0), VW'(tbl[e].exp_vecs));
      if (tbl[e].exp_vecs != 0) chk("tbl_vec", last_vec, build(tbl[e].base));
    end

    do_reset();
    fv.vector_ready_in = 1'b0;
    send_frame(16, 15, 100, 1'b0);
    send_frame(16, 15, 200, 1'b0);
    chk("stall_ready_low", VW'(fv.feature_ready_out), VW'(0));
    fv.feature_valid_in = 1'b1;
    fv.feature_data_in  = DW'(300);
    repeat (3) cycle();
    chk("stall_hold_data", fv.vector_data_out, build(100));
    fv.vector_ready_in = 1'b1;
    cycle();
    chk("stall_first", last_vec, build(100));
    fv.vector_ready_in = 1'b0;
    chk("stall_second_presented", fv.vector_data_out, build(200));
    send_frame(16, 15, 300, 1'b0);
    fv.vector_ready_in = 1'b1;
    cycle();
    chk("stall_second", last_vec, build(200));
    cycle();
    chk("stall_third", last_vec, build(300));
    cycle();

    do_reset();
    fv.vector_ready_in = 1'b0;
    send_frame(16, 15, 10, 1'b0);
    send_frame(16, 15, 20, 1'b1);
    chk("sim_consumed", last_vec, build(10));
    chk("sim_valid", VW'(fv.vector_valid_out), VW'(1));
    chk("sim_data", fv.vector_data_out, build(20));
    chk("sim_ready", VW'(fv.feature_ready_out), VW'(1));
    cycle();
    chk("sim_second", last_vec, build(20));
    chk("sim_empty", VW'(fv.vector_valid_out), VW'(0));

    do_reset();
    fv.vector_ready_in = 1'b0;
    send_frame(8, -1, 77, 1'b0);
    do_reset();
    fv.vector_ready_in = 1'b1;
    send_frame(16, 15, 400, 1'b0);
    repeat (2) cycle();
    chk("rst_mid_frame_vec", last_vec, build(400));
    chk("rst_mid_frame_err", VW'(fv.error_count_out), VW'(0));

    fv.vector_ready_in = 1'b0;
    send_frame(16, 15, 600, 1'b0);
    send_frame(16, 15, 700, 1'b0);
    do_reset();
    fv.vector_ready_in = 1'b1;
    send_frame(16, 15, 500, 1'b0);
    repeat (2) cycle();
    chk("rst_stall_vec", last_vec, build(500));
    chk("rst_stall_err", VW'(fv.error_count_out), VW'(0));

    do_reset();
    fv.vector_ready_in = 1'b1;
    p0  = n_pulses;
    p16 = n_pulses;
    for (int f = 0; f < 17; f++) begin
      if (f == 16) p16 = n_pulses;
      send_frame(5, 4, f * 10, 1'b0);
      cycle();
    end
    chk("sat_count", VW'(fv.error_count_out), VW'(ERR_MAX));
    chk("sat_pulses", VW'(n_pulses - p0), VW'(17));
    chk("sat_last_pulse", VW'(n_pulses - p16), VW'(1));

    do_reset();
    b = 0;
    len = 16;
    for (int c = 0; c < 3000; c++) begin
      fv.feature_valid_in = ($urandom_range(0, 9) < 7);
      fv.feature_data_in  = DW'($urandom);
      fv.feature_last_in  = (b == len - 1);
      fv.vector_ready_in  = $urandom_range(0, 1);
      cycle();
      if (last_acc) begin
        b++;
        if (b == len) begin
          b = 0;
          len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 16;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
